// File: rtl/fp_accum_ctrl.sv
// Packet accumulator that sequences a combinational float32 add/sub unit over a valid/ready stream.
// Optional build macro FP_ACC_DENORM_FLUSH_EN flushes subnormal elements to signed zero.
module fp_accum_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_sub,
    input  logic [31:0]      add_result,
    input  logic             add_exception,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_exception
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_OUT   = 1'b1;

    logic [0:0]       state;
    logic [31:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic             exc;
    logic [CNT_W-1:0] cnt_inc;
    logic             beat;

    assign in_ready = (state == ST_ACCUM);
    assign beat     = in_valid && in_ready;
    assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;

    assign add_a   = acc;
    assign add_sub = in_sub;
`ifdef FP_ACC_DENORM_FLUSH_EN
    assign add_b = (in_data[30:23] == 8'h00) ? {in_data[31], 31'h0} : in_data;
`else
    assign add_b = in_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_ACCUM;
            acc           <= 32'h0;
            cnt           <= '0;
            exc           <= 1'b0;
            out_valid     <= 1'b0;
            out_sum       <= 32'h0;
            out_count     <= '0;
            out_exception <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (beat) begin
                        if (in_last) begin
                            // An excepting last beat leaves the total at the pre-beat sum.
                            out_sum       <= add_exception ? acc : add_result;
                            out_count     <= cnt_inc;
                            out_exception <= exc | add_exception;
                            out_valid     <= 1'b1;
                            acc           <= 32'h0;
                            cnt           <= '0;
                            exc           <= 1'b0;
                            state         <= ST_OUT;
                        end else begin
                            if (!add_exception) acc <= add_result;
                            exc <= exc | add_exception;
                            cnt <= cnt_inc;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_ACCUM;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Directed bench for fp_accum_ctrl with a scoreboard queue and a behavioural truncating float32 add/sub unit.
module tb_fp_accum_ctrl;

    localparam int CNT_W = 4;

    typedef struct {
        logic [31:0] sum;
        logic [31:0] cnt;
        logic        exc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_sub, in_last;
    logic [31:0]      in_data;
    logic [31:0]      add_a, add_b, add_result;
    logic             add_sub, add_exception;
    logic             out_valid, out_ready, out_exception;
    logic [31:0]      out_sum;
    logic [CNT_W-1:0] out_count;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fp_accum_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sub(in_sub), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
        .add_result(add_result), .add_exception(add_exception),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_exception(out_exception)
    );

    // Behavioural unit: normal/zero operands, truncating alignment; Inf/NaN raises exception.
    function automatic logic [32:0] fp_unit(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [31:0] bb, x, y;
        logic [24:0] mx, my, m;
        int ex, ey, d;
        bb = {b[31] ^ sub, b[30:0]};
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {1'b1, 32'h7FC00000};
        if (a[30:0] == 31'h0) return {1'b0, bb};
        if (bb[30:0] == 31'h0) return {1'b0, a};
        if (a[30:0] >= bb[30:0]) begin x = a; y = bb; end
        else begin x = bb; y = a; end
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        d  = ex - ey;
        mx = {2'b01, x[22:0]};
        my = (d > 24) ? 25'h0 : ({2'b01, y[22:0]} >> d);
        m  = (x[31] == y[31]) ? mx + my : mx - my;
        if (m == 25'h0) return {1'b0, 32'h0};
        if (m[24]) begin m = m >> 1; ex++; end
        while (!m[23]) begin m = m << 1; ex--; end
        return {1'b0, x[31], ex[7:0], m[22:0]};
    endfunction

    always_comb {add_exception, add_result} = fp_unit(add_a, add_b, add_sub);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic sub, input logic last);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sub = sub; in_last = last;
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0; in_data = 32'hDEADBEEF;
    endtask

    task automatic push(input logic [31:0] s, input int c, input logic e);
        exp_t t;
        t.sum = s; t.cnt = c; t.exc = e;
        sb.push_back(t);
    endtask

    task automatic collect(input string tag);
        exp_t t;
        int   n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'h1, 32'h0 + 32'(sb.size()));
        end else begin
            t = sb.pop_front();
            chk({tag, "_sum"}, out_sum, t.sum);
            chk({tag, "_count"}, {{(32-CNT_W){1'b0}}, out_count}, t.cnt);
            chk({tag, "_exc"}, {31'h0, out_exception}, {31'h0, t.exc});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_drained"}, {31'h0, out_valid}, 32'h0);
        chk({tag, "_ready_back"}, {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_sub = 1'b0;
        in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_sum", out_sum, 32'h0);
        chk("rst_out_count", {{(32-CNT_W){1'b0}}, out_count}, 32'h0);
        chk("rst_out_exc", {31'h0, out_exception}, 32'h0);
        chk("rst_add_a", add_a, 32'h0);
        rst_n = 1'b1;

        // 1+2+3, with a one-cycle latency check
        push(32'h40C00000, 3, 1'b0);
        beat(32'h3F800000, 1'b0, 1'b0);
        beat(32'h40000000, 1'b0, 1'b0);
        beat(32'h40400000, 1'b0, 1'b1);
        chk("t1_latency", {31'h0, out_valid}, 32'h1);
        chk("t1_in_ready_low", {31'h0, in_ready}, 32'h0);
        collect("t1");

        // 5 - 2
        push(32'h40400000, 2, 1'b0);
        beat(32'h40A00000, 1'b0, 1'b0);
        beat(32'h40000000, 1'b1, 1'b1);
        collect("t2");

        // infinity beat excepts and is skipped
        push(32'h40000000, 3, 1'b1);
        beat(32'h3F800000, 1'b0, 1'b0);
        beat(32'h7F800000, 1'b0, 1'b0);
        beat(32'h3F800000, 1'b0, 1'b1);
        collect("t3");

        // back-pressure on output
        push(32'h40400000, 2, 1'b0);
        beat(32'h3F800000, 1'b0, 1'b0);
        beat(32'h40000000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 32'h3F800000; in_last = 1'b1;
            chk("t4_hold_valid", {31'h0, out_valid}, 32'h1);
            chk("t4_hold_in_ready", {31'h0, in_ready}, 32'h0);
            chk("t4_hold_sum", out_sum, 32'h40400000);
        end
        in_valid = 1'b0; in_last = 1'b0;
        collect("t4");

        // reset mid-packet discards partial sum
        beat(32'h40000000, 1'b0, 1'b0);
        beat(32'h40000000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("t5_rst_acc", add_a, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        push(32'h3F800000, 1, 1'b0);
        beat(32'h3F800000, 1'b0, 1'b1);
        collect("t5");

        // reset while result is waiting in OUT
        push(32'h40000000, 2, 1'b0);
        beat(32'h3F800000, 1'b0, 1'b0);
        beat(32'h3F800000, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5b_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("t5b_rst_sum", out_sum, 32'h0);
        chk("t5b_rst_count", {{(32-CNT_W){1'b0}}, out_count}, 32'h0);
        chk("t5b_rst_in_ready", {31'h0, in_ready}, 32'h1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // subnormal single element
`ifdef FP_ACC_DENORM_FLUSH_EN
        push(32'h00000000, 1, 1'b0);
`else
        push(32'h00000001, 1, 1'b0);
`endif
        beat(32'h00000001, 1'b0, 1'b1);
        collect("t6");

        // idle cycles with garbage data do not disturb accumulation
        push(32'h40000000, 2, 1'b0);
        beat(32'h3F800000, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            in_data = 32'h7F800000;
            chk("t7_idle_no_valid", {31'h0, out_valid}, 32'h0);
        end
        beat(32'h3F800000, 1'b0, 1'b1);
        collect("t7");

        // counter saturation at 2^CNT_W-1
        push(32'h00000000, (1 << CNT_W) - 1, 1'b0);
        for (int i = 0; i < 19; i++) beat(32'h00000000, 1'b0, 1'b0);
        beat(32'h00000000, 1'b0, 1'b1);
        collect("t8");

        // single-element subtract: 0 - 3
        push(32'hC0400000, 1, 1'b0);
        beat(32'h40400000, 1'b1, 1'b1);
        collect("t9");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
